// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline stages.
// Holds the result-select encodings, the MEM-stage FSM state type and XLEN.
// Imported by mem_stage_wb and memwb_reg.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] RSLT_ALU = 2'b00;
   localparam logic [1:0] RSLT_MEM = 2'b01;
   localparam logic [1:0] RSLT_PC4 = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with bubble insertion and asynchronous reset.
// Ports: clk/rst; bubble forces an all-zero entry; the *m-side operands
//        are loaded otherwise and appear on the *w outputs one cycle later.
module memwb_reg
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            bubble,
   input  logic            regWrt,
   input  logic [1:0]      rsltSrc,
   input  logic [XLEN-1:0] aluRslt,
   input  logic [XLEN-1:0] rdData,
   input  logic [XLEN-1:0] pc4,
   input  logic [4:0]      rd,
   output logic            regWrtw,
   output logic [1:0]      rsltSrcw,
   output logic [XLEN-1:0] aluRsltw,
   output logic [XLEN-1:0] rdDataw,
   output logic [XLEN-1:0] pc4w,
   output logic [4:0]      rdw
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regWrtw  <= 1'b0;
         rsltSrcw <= 2'b00;
         aluRsltw <= '0;
         rdDataw  <= '0;
         pc4w     <= '0;
         rdw      <= 5'd0;
      end else if (bubble) begin
         regWrtw  <= 1'b0;
         rsltSrcw <= 2'b00;
         aluRsltw <= '0;
         rdDataw  <= '0;
         pc4w     <= '0;
         rdw      <= 5'd0;
      end else begin
         regWrtw  <= regWrt;
         rsltSrcw <= rsltSrc;
         aluRsltw <= aluRslt;
         rdDataw  <= rdData;
         pc4w     <= pc4;
         rdw      <= rd;
      end
   end

endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage: data-memory req/ack bus master, stall generation, timeout and
// misalign detection, feeding the MEM/WB register (memwb_reg).
// Ports: EX/MEM operands in (*m), dm* bus, stallm to hazard unit, MEM/WB
//        outputs (*w), sticky busErr, one-cycle misalign pulse.
module mem_stage_wb
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNTW    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regWrtm,
   input  logic        memWrtm,
   input  logic [1:0]  rsltSrcm,
   input  logic [31:0] aluRsltm,
   input  logic [31:0] wrtDm,
   input  logic [31:0] pc4m,
   input  logic [4:0]  rdm,
   output logic        dmReq,
   output logic        dmWe,
   output logic [31:0] dmAddr,
   output logic [31:0] dmWdata,
   input  logic [31:0] dmRdata,
   input  logic        dmAck,
   output logic        stallm,
   output logic        regWrtw,
   output logic [1:0]  rsltSrcw,
   output logic [31:0] aluRsltw,
   output logic [31:0] rdDataw,
   output logic [31:0] pc4w,
   output logic [4:0]  rdw,
   output logic        busErr,
   output logic        misalign
);

   localparam logic [CNTW-1:0] TMO = CNTW'(TIMEOUT);

   mem_state_t      state, state_nxt;
   logic [CNTW-1:0] cnt, cnt_nxt;
   logic            acc, mis, req, stall, done, tmo;
   logic            is_load;
   logic [31:0]     rd_data;

   always_comb begin
      acc       = memWrtm | (rsltSrcm == RSLT_MEM);
      mis       = acc & (aluRsltm[1:0] != 2'b00);
      state_nxt = state;
      cnt_nxt   = cnt;
      req       = 1'b0;
      stall     = 1'b0;
      done      = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (acc && !mis) begin
               req = 1'b1;
               if (dmAck) begin
                  done = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_nxt = WAIT;
                  cnt_nxt   = CNTW'(1);
               end
            end else if (!acc) begin
               done = 1'b1;
            end
         end
         WAIT: begin
            // An ack arriving on the timeout cycle still completes the access.
            if (dmAck) begin
               req       = 1'b1;
               done      = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == TMO) begin
               tmo       = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               req   = 1'b1;
               stall = 1'b1;
               if (cnt != '1) cnt_nxt = cnt + CNTW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Gate with rst so the bus request drops the instant reset asserts,
   // even while the inputs still describe a pending access.
   assign dmReq   = req & ~rst;
   assign stallm  = stall & ~rst;
   assign dmWe    = dmReq & memWrtm;
   assign dmAddr  = aluRsltm;
   assign dmWdata = wrtDm;

   assign is_load = (rsltSrcm == RSLT_MEM) & ~memWrtm;
   assign rd_data = is_load ? dmRdata : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         busErr   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         busErr   <= busErr | tmo;
         misalign <= (state == IDLE) & mis;
      end
   end

   memwb_reg u_memwb (
      .clk      (clk),
      .rst      (rst),
      .bubble   (~done),
      .regWrt   (regWrtm),
      .rsltSrc  (rsltSrcm),
      .aluRslt  (aluRsltm),
      .rdData   (rd_data),
      .pc4      (pc4m),
      .rd       (rdm),
      .regWrtw  (regWrtw),
      .rsltSrcw (rsltSrcw),
      .aluRsltw (aluRsltw),
      .rdDataw  (rdDataw),
      .pc4w     (pc4w),
      .rdw      (rdw)
   );

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb with TIMEOUT=4.
// Inputs change on the falling edge; combinational outputs are checked 2ns
// later, registered outputs at the following falling edge.
module tb_mem_stage_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        regWrtm = 1'b0;
   logic        memWrtm = 1'b0;
   logic [1:0]  rsltSrcm = 2'b00;
   logic [31:0] aluRsltm = '0;
   logic [31:0] wrtDm = '0;
   logic [31:0] pc4m = '0;
   logic [4:0]  rdm = '0;
   logic        dmReq, dmWe, stallm;
   logic [31:0] dmAddr, dmWdata;
   logic [31:0] dmRdata = '0;
   logic        dmAck = 1'b0;
   logic        regWrtw;
   logic [1:0]  rsltSrcw;
   logic [31:0] aluRsltw, rdDataw, pc4w;
   logic [4:0]  rdw;
   logic        busErr, misalign;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_wb #(.TIMEOUT(4), .CNTW(8)) dut (
      .clk(clk), .rst(rst),
      .regWrtm(regWrtm), .memWrtm(memWrtm), .rsltSrcm(rsltSrcm),
      .aluRsltm(aluRsltm), .wrtDm(wrtDm), .pc4m(pc4m), .rdm(rdm),
      .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata),
      .dmRdata(dmRdata), .dmAck(dmAck), .stallm(stallm),
      .regWrtw(regWrtw), .rsltSrcw(rsltSrcw), .aluRsltw(aluRsltw),
      .rdDataw(rdDataw), .pc4w(pc4w), .rdw(rdw),
      .busErr(busErr), .misalign(misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic mw, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] p4, input logic [4:0] rd);
      regWrtm = rw; memWrtm = mw; rsltSrcm = src;
      aluRsltm = alu; wrtDm = wd; pc4m = p4; rdm = rd;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_dmReq", dmReq, 0);
      chk("rst_stallm", stallm, 0);
      chk("rst_regWrtw", regWrtw, 0);
      chk("rst_busErr", busErr, 0);
      chk("rst_misalign", misalign, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // ALU pass-through; a stray ack in IDLE must be ignored
      drive(1, 0, 2'b00, 32'h1234, 32'h0, 32'h8, 5'd5);
      dmAck = 1'b1; dmRdata = 32'h1111_2222;
      #2;
      chk("alu_dmReq", dmReq, 0);
      chk("alu_stallm", stallm, 0);
      @(negedge clk);
      chk("alu_regWrtw", regWrtw, 1);
      chk("alu_aluRsltw", aluRsltw, 32'h1234);
      chk("alu_rdw", rdw, 5);
      chk("alu_pc4w", pc4w, 32'h8);
      chk("alu_rdDataw", rdDataw, 0);

      // Zero-wait load
      drive(1, 0, 2'b01, 32'h100, 32'h0, 32'hC, 5'd7);
      dmAck = 1'b1; dmRdata = 32'hDEAD_BEEF;
      #2;
      chk("zw_dmReq", dmReq, 1);
      chk("zw_dmWe", dmWe, 0);
      chk("zw_stallm", stallm, 0);
      @(negedge clk);
      chk("zw_rdDataw", rdDataw, 32'hDEAD_BEEF);
      chk("zw_rsltSrcw", rsltSrcw, 2'b01);
      chk("zw_rdw", rdw, 7);
      chk("zw_regWrtw", regWrtw, 1);

      // Store with 3 wait cycles, ack on the 4th cycle
      drive(0, 1, 2'b00, 32'h40, 32'hA5A5_A5A5, 32'h10, 5'd0);
      dmAck = 1'b0; dmRdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("st_stallm", stallm, 1);
         chk("st_dmWe", dmWe, 1);
         chk("st_dmAddr", dmAddr, 32'h40);
         chk("st_dmWdata", dmWdata, 32'hA5A5_A5A5);
         @(negedge clk);
         chk("st_bubble_alu", aluRsltw, 0);
      end
      dmAck = 1'b1; dmRdata = 32'h7777_7777;
      #2;
      chk("st_ack_stallm", stallm, 0);
      chk("st_ack_dmReq", dmReq, 1);
      @(negedge clk);
      chk("st_done_alu", aluRsltw, 32'h40);
      chk("st_done_rdData", rdDataw, 0);
      chk("st_done_regWrtw", regWrtw, 0);
      chk("st_busErr", busErr, 0);

      // Load acked exactly when the counter reaches TIMEOUT: ack wins
      drive(1, 0, 2'b01, 32'h80, 32'h0, 32'h14, 5'd6);
      dmAck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("edge_stallm", stallm, 1);
         @(negedge clk);
      end
      dmAck = 1'b1; dmRdata = 32'h0BAD_F00D;
      #2;
      chk("edge_stallm_ack", stallm, 0);
      chk("edge_dmReq_ack", dmReq, 1);
      @(negedge clk);
      chk("edge_rdDataw", rdDataw, 32'h0BAD_F00D);
      chk("edge_busErr", busErr, 0);

      // Timeout: load never acked
      drive(1, 0, 2'b01, 32'h200, 32'h0, 32'h18, 5'd9);
      dmAck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("to_stallm", stallm, 1);
         chk("to_dmReq", dmReq, 1);
         @(negedge clk);
      end
      #2;
      chk("to_drop_dmReq", dmReq, 0);
      chk("to_drop_stallm", stallm, 0);
      @(negedge clk);
      chk("to_busErr", busErr, 1);
      chk("to_regWrtw", regWrtw, 0);
      drive(1, 0, 2'b00, 32'h55, 32'h0, 32'h1C, 5'd3);
      @(negedge clk);
      chk("to_sticky", busErr, 1);
      chk("to_after_alu", aluRsltw, 32'h55);

      // Misaligned load
      drive(1, 0, 2'b01, 32'h102, 32'h0, 32'h20, 5'd4);
      #2;
      chk("mis_dmReq", dmReq, 0);
      chk("mis_stallm", stallm, 0);
      @(negedge clk);
      chk("mis_pulse", misalign, 1);
      chk("mis_regWrtw", regWrtw, 0);
      drive(1, 0, 2'b00, 32'h4, 32'h0, 32'h24, 5'd2);
      @(negedge clk);
      chk("mis_pulse_end", misalign, 0);

      // Reset mid-WAIT
      drive(1, 0, 2'b01, 32'h300, 32'h0, 32'h28, 5'd8);
      dmAck = 1'b0;
      @(negedge clk);
      #2;
      chk("rw_pre_stallm", stallm, 1);
      rst = 1'b1;
      #1;
      chk("rw_dmReq", dmReq, 0);
      chk("rw_stallm", stallm, 0);
      chk("rw_busErr", busErr, 0);
      chk("rw_regWrtw", regWrtw, 0);
      chk("rw_aluRsltw", aluRsltw, 0);
      @(negedge clk);
      rst = 1'b0;
      // Back in IDLE: a misaligned access must not issue a request
      drive(1, 0, 2'b01, 32'h302, 32'h0, 32'h28, 5'd8);
      #2;
      chk("rw_idle_dmReq", dmReq, 0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_wb.md
Name: mem_stage_wb

Overview:
- MEM-stage data-memory bus master plus MEM/WB pipeline register for the in-order RV32I core.
- Consumes the EX/MEM register outputs and issues word load/store requests on a req/ack data-memory port.
- Stalls the pipeline while an access is outstanding, then presents writeback operands to the WB stage.
- Flags bus timeouts and misaligned accesses.

Parameters:
- TIMEOUT, 16, WAIT cycles without dmAck before an access is aborted (range 1..255).
- CNTW, 8, width of the timeout counter.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- regWrtm  in  1  EX/MEM register-write enable
- memWrtm  in  1  EX/MEM store enable
- rsltSrcm  in  2  EX/MEM result select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- aluRsltm  in  32  effective address / ALU result
- wrtDm  in  32  store data
- pc4m  in  32  PC+4
- rdm  in  5  destination register
- dmReq  out  1  data-memory request
- dmWe  out  1  write strobe, valid with dmReq
- dmAddr  out  32  word address (aluRsltm)
- dmWdata  out  32  store data (wrtDm)
- dmRdata  in  32  read data, valid with dmAck
- dmAck  in  1  access complete
- stallm  out  1  to hazard unit: freeze PC, IF/ID, ID/EX, EX/MEM
- regWrtw, rsltSrcw[1:0], aluRsltw[31:0], rdDataw[31:0], pc4w[31:0], rdw[4:0]  out  MEM/WB register
- busErr  out  1  sticky timeout flag
- misalign  out  1  one-cycle pulse

Behaviour:
- Clocking and reset:
  - One clock domain; all state on posedge clk.
  - rst asynchronously clears every register and output to 0: state=IDLE, counter=0, busErr=0, misalign=0.
  - dmReq deasserts immediately on reset, including mid-WAIT.
- Access decode:
  - acc = memWrtm | (rsltSrcm==01).
  - mis = acc & (aluRsltm[1:0]!=0).
- FSM states: IDLE, WAIT.
- IDLE:
  - acc & !mis: dmReq=1 combinationally, dmWe=memWrtm.
    - dmAck same cycle: zero-wait access, no stall, stay IDLE.
    - Otherwise: stallm=1, go to WAIT, counter=1.
  - mis: no request. misalign=1 next cycle. MEM/WB gets a bubble (regWrtw=0). No stall.
  - !acc: plain pass-through, 1-cycle latency into MEM/WB.
- WAIT:
  - dmReq=1 held. dmAddr, dmWdata and dmWe stay stable because EX/MEM is frozen by stallm.
  - stallm = !dmAck.
  - dmAck: capture, go to IDLE, counter=0.
  - No ack and counter==TIMEOUT: busErr<=1, drop dmReq, stallm=0, MEM/WB gets a bubble, go to IDLE.
  - Otherwise: counter+1. The counter saturates and never wraps.
- MEM/WB register update, every cycle:
  - Completing access or pass-through: load all MEM/WB fields from the m-side inputs; rdDataw = dmRdata on loads, else 0.
  - Stall cycles, timeout and misalign: bubble (regWrtw=0, rdw=0, other fields 0).
- Stores: regWrtw follows regWrtm (normally 0); rdDataw=0.
- dmAck in IDLE without dmReq: ignored.
- dmAck on the same cycle the counter reaches TIMEOUT: ack wins, no error.
- busErr clears only on rst.
- Latency: non-memory op 1 cycle; memory op 1 + N wait cycles, where N is the number of cycles until dmAck.

Decomposition:
- Shared package core_pkg:
  - rsltSrc encodings: RSLT_ALU=2'b00, RSLT_MEM=2'b01, RSLT_PC4=2'b10.
  - mem_state_t enum {IDLE, WAIT}.
  - XLEN=32.
- One sub-module, memwb_reg: the MEM/WB pipeline register with bubble input and async reset.
- FSM, counter and bus outputs stay in the top level.

Test Plan:
- Reset mid-WAIT: assert rst during a stalled load -> dmReq=0 and stallm=0 the same cycle, all outputs 0, state IDLE.
- ALU op, pass-through: aluRsltm=0x1234, rdm=5, regWrtm=1, rsltSrcm=00 -> next cycle regWrtw=1, aluRsltw=0x1234, rdw=5; dmReq never asserted.
- Zero-wait load: addr 0x100, dmAck=1 same cycle with dmRdata=0xDEADBEEF -> stallm stays 0, next cycle rdDataw=0xDEADBEEF, rsltSrcw=01.
- 3-wait store: memWrtm=1, addr 0x40, wrtDm=0xA5A5A5A5, ack on 4th cycle -> stallm=1 for 3 cycles, dmWe=1 and dmAddr=0x40 stable throughout, bubbles into MEM/WB, busErr=0.
- Timeout: TIMEOUT=4, load with no ack -> 4 stall cycles, then busErr=1 (sticky), regWrtw=0, dmReq drops.
- Misaligned load: addr 0x102 -> no dmReq, misalign pulses 1 cycle, regWrtw=0, no stall.
